// File: rtl/oled_cmd_rx.sv
// SPI receive-side responder: oversamples spi_clk/mosi, assembles bytes and decodes SSD1306-style init commands.
// Define SPI_RX_MSB_FIRST_EN to assemble bytes MSB first (default is LSB first).
module oled_cmd_rx #(
  parameter int          SYNC_STAGES   = 2,
  parameter int          IDLE_TIMEOUT  = 64,
  parameter logic [7:0]  CONTRAST_RST  = 8'h7F,
  parameter logic [7:0]  PRECHARGE_RST = 8'h22
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_clk,
  input  logic       mosi,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic [7:0] contrast,
  output logic [7:0] precharge,
  output logic       charge_pump_en,
  output logic       display_on,
  output logic       entire_on,
  output logic       arg_pending,
  output logic       cmd_err
);

  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {CMD, ARG_CP, ARG_CON, ARG_PRE} state_t;

  logic [1:0]             rst_sync;
  logic                   srst_n;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_dly;
  logic                   rise;
  logic                   mosi_s;
  logic [2:0]             bit_cnt;
  logic [2:0]             bit_pos;
  logic [7:0]             shift_reg;
  logic [7:0]             shift_next;
  logic [TW-1:0]          timer;
  logic                   timeout_hit;
  state_t                 state;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign srst_n = rst_sync[1];

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      sclk_dly  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_dly  <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign rise   = sclk_sync[SYNC_STAGES-1] & ~sclk_dly;
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

`ifdef SPI_RX_MSB_FIRST_EN
  assign bit_pos = 3'd7 - bit_cnt;
`else
  assign bit_pos = bit_cnt;
`endif

  always_comb begin
    shift_next          = shift_reg;
    shift_next[bit_pos] = mosi_s;
  end

  // Fires once, on the cycle the idle count would reach the limit.
  assign timeout_hit = !rise && (timer == TW'(IDLE_TIMEOUT - 1));

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
      timer     <= '0;
      rx_byte   <= 8'h00;
      rx_valid  <= 1'b0;
    end else if (rise) begin
      bit_cnt  <= bit_cnt + 3'd1;
      timer    <= '0;
      rx_valid <= (bit_cnt == 3'd7);
      if (bit_cnt == 3'd7) begin
        rx_byte   <= shift_next;
        shift_reg <= 8'h00;
      end else begin
        shift_reg <= shift_next;
      end
    end else begin
      rx_valid <= 1'b0;
      if (timer != TW'(IDLE_TIMEOUT)) timer <= timer + TW'(1);
      if (timeout_hit) begin
        bit_cnt   <= 3'd0;
        shift_reg <= 8'h00;
      end
    end
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state          <= CMD;
      contrast       <= CONTRAST_RST;
      precharge      <= PRECHARGE_RST;
      charge_pump_en <= 1'b0;
      display_on     <= 1'b0;
      entire_on      <= 1'b0;
      arg_pending    <= 1'b0;
      cmd_err        <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      if (rx_valid) begin
        case (state)
          CMD: begin
            case (rx_byte)
              8'h8D: begin state <= ARG_CP;  arg_pending <= 1'b1; end
              8'h81: begin state <= ARG_CON; arg_pending <= 1'b1; end
              8'hD9: begin state <= ARG_PRE; arg_pending <= 1'b1; end
              8'hA4: entire_on  <= 1'b0;
              8'hA5: entire_on  <= 1'b1;
              8'hAE: display_on <= 1'b0;
              8'hAF: display_on <= 1'b1;
              8'h00: state      <= CMD;
              default: cmd_err  <= 1'b1;
            endcase
          end
          ARG_CP: begin
            charge_pump_en <= rx_byte[2];
            state          <= CMD;
            arg_pending    <= 1'b0;
          end
          ARG_CON: begin
            contrast    <= rx_byte;
            state       <= CMD;
            arg_pending <= 1'b0;
          end
          default: begin
            precharge   <= rx_byte;
            state       <= CMD;
            arg_pending <= 1'b0;
          end
        endcase
      end else if (timeout_hit && arg_pending) begin
        // Link went quiet while an argument was owed: abandon the command.
        state       <= CMD;
        arg_pending <= 1'b0;
        cmd_err     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_oled_cmd_rx.sv
// Bench for oled_cmd_rx: drives SPI bytes, predicts decoded state with a behavioural model and checks every cycle.
module tb_oled_cmd_rx;

  localparam int IDLE_TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_clk = 1'b0;
  logic       mosi = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] contrast;
  logic [7:0] precharge;
  logic       charge_pump_en;
  logic       display_on;
  logic       entire_on;
  logic       arg_pending;
  logic       cmd_err;

  oled_cmd_rx #(.SYNC_STAGES(2), .IDLE_TIMEOUT(IDLE_TIMEOUT),
                .CONTRAST_RST(8'h7F), .PRECHARGE_RST(8'h22)) dut (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .mosi(mosi),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .contrast(contrast),
    .precharge(precharge), .charge_pump_en(charge_pump_en),
    .display_on(display_on), .entire_on(entire_on),
    .arg_pending(arg_pending), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: decoded register file plus what it is waiting for.
  logic [7:0] m_con, m_pre;
  logic       m_cp, m_disp, m_ent;
  int         m_wait;          // 0 = opcode expected, else the opcode whose argument is owed
  logic [7:0] exp_q[$];
  int         err_seen = 0;
  int         err_exp = 0;
  bit         chk_en = 0;
  bit         in_stall = 0;
  bit         upd = 0;
  logic [7:0] upd_byte;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_con = 8'h7F; m_pre = 8'h22; m_cp = 0; m_disp = 0; m_ent = 0; m_wait = 0;
    exp_q.delete();
    upd = 0;
  endtask

  task automatic model_apply(input logic [7:0] b, output bit err);
    err = 0;
    if (m_wait == 'h8D)      begin m_cp  = b[2]; m_wait = 0; end
    else if (m_wait == 'h81) begin m_con = b;    m_wait = 0; end
    else if (m_wait == 'hD9) begin m_pre = b;    m_wait = 0; end
    else if (b == 8'h8D || b == 8'h81 || b == 8'hD9) m_wait = int'(b);
    else if (b == 8'hA4 || b == 8'hA5) m_ent  = b[0];
    else if (b == 8'hAE || b == 8'hAF) m_disp = b[0];
    else if (b != 8'h00) err = 1;
  endtask

  // Compare process: one pass per cycle, away from the active edge.
  initial begin
    bit e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e = 0;
        if (upd) begin model_apply(upd_byte, e); upd = 0; end
        if (cmd_err) err_seen++;
        if (e) err_exp++;
        if (!in_stall) chk("cmd_err", 32'(cmd_err), 32'(e));
        if (rx_valid) begin
          if (exp_q.size() == 0) chk("unexpected rx_valid", 32'(rx_valid), 32'd0);
          else begin
            upd_byte = exp_q.pop_front();
            chk("rx_byte", 32'(rx_byte), 32'(upd_byte));
            upd = 1;
          end
        end
        chk("contrast", 32'(contrast), 32'(m_con));
        chk("precharge", 32'(precharge), 32'(m_pre));
        chk("charge_pump_en", 32'(charge_pump_en), 32'(m_cp));
        chk("display_on", 32'(display_on), 32'(m_disp));
        chk("entire_on", 32'(entire_on), 32'(m_ent));
        if (!in_stall) chk("arg_pending", 32'(arg_pending), 32'(m_wait != 0));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b, input int half);
    mosi = b;
    tick(half);
    spi_clk = 1'b1;
    tick(half);
    spi_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int half);
    logic [7:0] v;
    v = b;
    exp_q.push_back(b);
    for (int i = 0; i < 8; i++) begin
`ifdef SPI_RX_MSB_FIRST_EN
      send_bit(v[7-i], half);
`else
      send_bit(v[i], half);
`endif
    end
  endtask

  task automatic send_partial(input int nbits, input int half);
    for (int i = 0; i < nbits; i++) send_bit(1'($urandom_range(0, 1)), half);
  endtask

  // Quiet long enough for the idle timer to fire; an owed argument becomes an error.
  task automatic stall();
    in_stall = 1;
    tick(IDLE_TIMEOUT + 10);
    if (m_wait != 0) begin m_wait = 0; err_exp++; end
    in_stall = 0;
    tick(1);
    chk("timeout err count", 32'(err_seen), 32'(err_exp));
    chk("arg_pending after timeout", 32'(arg_pending), 32'd0);
  endtask

  task automatic chk_reset_values();
    chk("rst rx_byte", 32'(rx_byte), 32'h00);
    chk("rst rx_valid", 32'(rx_valid), 32'd0);
    chk("rst contrast", 32'(contrast), 32'h7F);
    chk("rst precharge", 32'(precharge), 32'h22);
    chk("rst charge_pump_en", 32'(charge_pump_en), 32'd0);
    chk("rst display_on", 32'(display_on), 32'd0);
    chk("rst entire_on", 32'(entire_on), 32'd0);
    chk("rst arg_pending", 32'(arg_pending), 32'd0);
    chk("rst cmd_err", 32'(cmd_err), 32'd0);
  endtask

  initial begin
    logic [7:0] pool [8];
    logic [7:0] b;
    pool[0] = 8'h8D; pool[1] = 8'h81; pool[2] = 8'hD9; pool[3] = 8'hA4;
    pool[4] = 8'hA5; pool[5] = 8'hAE; pool[6] = 8'hAF; pool[7] = 8'h00;
    model_reset();
    tick(3);
    chk_reset_values();
    rst_n = 1'b1;
    tick(4);
    chk_en = 1;

    // Abandoned argument: one error, contrast untouched, decoder recovers.
    send_byte(8'h81, 4);
    stall();
    chk("contrast kept", 32'(contrast), 32'h7F);
    send_byte(8'hAF, 4); tick(6);
    chk("display_on after AF", 32'(display_on), 32'd1);

    send_byte(8'h8D, 4); send_byte(8'h14, 4); tick(6);
    chk("charge_pump_en", 32'(charge_pump_en), 32'd1);
    chk("rx_byte 14", 32'(rx_byte), 32'h14);

    send_byte(8'h81, 4); send_byte(8'hCF, 4);
    send_byte(8'hD9, 4); send_byte(8'hF1, 4); tick(6);
    chk("contrast CF", 32'(contrast), 32'hCF);
    chk("precharge F1", 32'(precharge), 32'hF1);

    send_byte(8'hA5, 4); tick(6);
    chk("entire_on set", 32'(entire_on), 32'd1);
    send_byte(8'hAF, 4); send_byte(8'hA4, 4); tick(6);
    chk("entire_on clr", 32'(entire_on), 32'd0);
    chk("display_on kept", 32'(display_on), 32'd1);
    send_byte(8'hAE, 4); tick(6);
    chk("display_on clr", 32'(display_on), 32'd0);

    // Partial byte is dropped by the idle timer.
    send_partial(5, 4);
    stall();
    send_byte(8'hAF, 4); tick(6);
    chk("rx_byte AF", 32'(rx_byte), 32'hAF);
    chk("display_on partial", 32'(display_on), 32'd1);

    // Reset in the middle of an argument byte.
    send_byte(8'h81, 4);
    send_partial(4, 4);
    #1;
    chk_en = 0;
    rst_n = 1'b0;
    #1;
    chk_reset_values();
    model_reset();
    tick(3);
    rst_n = 1'b1;
    tick(4);
    chk_en = 1;
    send_byte(8'hAF, 4); tick(6);
    chk("display_on after reset", 32'(display_on), 32'd1);
    chk("arg_pending after reset", 32'(arg_pending), 32'd0);

    // Randomised traffic: weighted opcodes, random arguments, timing and gaps.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) b = 8'($urandom);
      else b = pool[$urandom_range(0, 7)];
      if (m_wait != 0) b = 8'($urandom);
      send_byte(b, int'($urandom_range(3, 6)));
      tick(int'($urandom_range(0, 15)));
    end
    tick(10);
    chk("final err count", 32'(err_seen), 32'(err_exp));
    chk("all bytes received", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Runaway guard.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/oled_cmd_rx.md
Name: oled_cmd_rx

Overview:
- SPI receive-side responder for the OLED command link: it sits on the far end of the 1-bit mosi/spi_clk stream the controller drives.
- Oversamples spi_clk/mosi in the system clock domain, deserialises bytes, and decodes the SSD1306-style init command set into a shadow register file.
- Used as an on-chip loopback checker and as a bench/display model for the command transmitter.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on spi_clk and mosi (legal ≥2)
- IDLE_TIMEOUT, 64, clk cycles without an spi_clk rise before bit/arg state is discarded
- CONTRAST_RST, 8'h7F, reset value of contrast
- PRECHARGE_RST, 8'h22, reset value of precharge

Ports:
- clk  in  1  system clock; must be ≥4× spi_clk frequency
- rst_n  in  1  asynchronous active-low reset
- spi_clk  in  1  serial clock from the transmitter; idles low, data is valid on its rising edge
- mosi  in  1  serial data
- rx_byte  out  8  last assembled byte
- rx_valid  out  1  one-cycle pulse when rx_byte updates
- contrast  out  8  value from the last 0x81 argument
- precharge  out  8  value from the last 0xD9 argument
- charge_pump_en  out  1  bit 2 of the last 0x8D argument
- display_on  out  1  set by 0xAF, cleared by 0xAE
- entire_on  out  1  set by 0xA5, cleared by 0xA4
- arg_pending  out  1  high while an argument byte is awaited
- cmd_err  out  1  one-cycle pulse on an unknown opcode or timeout mid-argument

Behaviour:
- Reset (async assert, sync-released internally):
  - rx_byte=0, rx_valid=0, contrast=CONTRAST_RST, precharge=PRECHARGE_RST.
  - charge_pump_en=0, display_on=0, entire_on=0, arg_pending=0, cmd_err=0.
  - Bit counter=0, timer=0, FSM=CMD.
- Front end:
  - spi_clk and mosi each pass through SYNC_STAGES flops.
  - A rise is detected when the synced spi_clk is 1 and its delayed copy is 0.
- Shifting:
  - On each rise, the synced mosi is stored in bit position bit_cnt (LSB first: first bit → bit 0), and bit_cnt increments (3-bit).
  - On the rise with bit_cnt==7: bit_cnt wraps to 0, rx_byte gets the full byte, and rx_valid pulses the next cycle.
  - Latency: rx_valid rises SYNC_STAGES+2 clk cycles after the 8th raw spi_clk rise (±1 cycle, asynchronous sampling).
- Idle timer:
  - Cleared on every rise; otherwise increments, saturating at IDLE_TIMEOUT.
  - On reaching IDLE_TIMEOUT: bit_cnt=0, any partial byte is discarded.
  - If arg_pending was set: FSM returns to CMD and cmd_err pulses.
  - A rise and the timeout in the same cycle: the rise wins and the timer clears.
- Decoder FSM (advances on rx_valid only; register updates are visible the cycle after rx_valid):
  - CMD, byte 0x8D → ARG_CP, arg_pending=1.
  - CMD, byte 0x81 → ARG_CON, arg_pending=1.
  - CMD, byte 0xD9 → ARG_PRE, arg_pending=1.
  - CMD, byte 0xA4 / 0xA5 → entire_on=0 / 1; stay in CMD.
  - CMD, byte 0xAE / 0xAF → display_on=0 / 1; stay in CMD.
  - CMD, byte 0x00 → ignored (padding); no error.
  - CMD, any other byte → cmd_err pulse; stay in CMD.
  - ARG_CP → charge_pump_en = byte[2]; back to CMD, arg_pending=0.
  - ARG_CON → contrast = byte; back to CMD, arg_pending=0.
  - ARG_PRE → precharge = byte; back to CMD, arg_pending=0.
  - Argument bytes are never interpreted as opcodes, including 0xAF.
- Reset mid-byte or mid-argument: everything returns to reset values immediately; the next rise after release starts bit 0.

Optional Feature:
- Macro SPI_RX_MSB_FIRST_EN.
- Defined: the first received bit lands in bit 7 and bit positions decrement.
- Undefined (default): LSB first, as described above.
- Decoder and timing are identical in both builds.

Test Plan:
- Reset, then send 0x8D,0x14 LSB-first (spi_clk period 8 clk) → two rx_valid pulses (rx_byte 0x8D then 0x14), charge_pump_en=1, cmd_err never pulses.
- Send 0x81,0xCF,0xD9,0xF1 → contrast=0xCF, precharge=0xF1, arg_pending high only between each opcode and its argument.
- Send 0xA5,0xAF then 0xA4 → entire_on 1 then 0, display_on=1; then 0xAE → display_on=0.
- Send 0x81, then stall IDLE_TIMEOUT+5 cycles → one cmd_err pulse, arg_pending=0, contrast stays 0x7F; next 0xAF sets display_on=1.
- Send 5 bits, stall past the timeout, then send 0xAF → rx_byte=0xAF, display_on=1 (partial byte discarded).
- Assert rst_n low mid-way through the 0xCF argument of 0x81 → all outputs return to reset values that cycle; the next 0xAF is decoded correctly.
